me_wb_pipe_reg: RTL and testbench
=================================

Name: me_wb_pipe_reg

Overview:
- Parametrised MEM->WB pipeline register; successor to the fixed enable-only stage register.
- Adds a valid/ready handshake on both sides, a one-entry skid buffer for full throughput under downstream stall, and a synchronous flush.
- Adds a configurable payload width and a valid-qualified register-write strobe.
- Sits between the memory stage and the writeback/regfile write port.

Parameters:
- DBITS, 32, result data width
- REG_INDEX_BIT_WIDTH, 4, destination register index width
- OPBITS, 4, width of op and func fields
- CNTBITS, 16, stall counter width (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; kill all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- op  in  OPBITS  opcode
- func  in  OPBITS  function code
- result  in  DBITS  ALU/memory result
- rd  in  REG_INDEX_BIT_WIDTH  destination register
- wrReg  in  1  entry writes the register file
- out_valid  out  1  ME_* outputs hold a valid entry
- out_ready  in  1  downstream consumes this cycle
- ME_op  out  OPBITS  registered op
- ME_func  out  OPBITS  registered func
- ME_result  out  DBITS  registered result
- ME_rd  out  REG_INDEX_BIT_WIDTH  registered rd
- ME_wrReg  out  1  registered wrReg AND out_valid
- stall_cnt  out  CNTBITS  present only with ME_STALL_CNT_EN

Behaviour:
- Storage: a main register (drives ME_*) and a skid register, each with its own valid bit.
- Clock and reset: one clock domain. On reset assertion, all payload registers, both valid bits and stall_cnt go to 0 immediately.
- Outputs in reset: out_valid=0, ME_*=0, in_ready=1.
- in_ready = !skid_valid. It is a registered-state decode only, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- States, decoded from the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - TWO: main=1, skid=1.
- Transitions (when flush=0):
  - EMPTY: on accept -> ONE, input loaded into main.
  - ONE, accept & consume: stay ONE, main reloaded.
  - ONE, accept & !consume: -> TWO, input captured in skid.
  - ONE, !accept & consume: -> EMPTY.
  - ONE, neither: hold.
  - TWO, consume: skid moves to main -> ONE. No accept is possible because in_ready=0.
  - TWO, !consume: hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Order is strictly preserved. The skid entry is never presented ahead of main.
- Payload registers load only on a transfer. When a valid bit is cleared, the payload holds its stale value, but ME_wrReg is forced to 0 whenever out_valid=0.
- flush=1:
  - Both valid bits clear next edge, and any input offered that cycle is dropped.
  - Flush has priority over accept and consume. A consume in the flush cycle still counts downstream.
- Reset mid-transfer: any entry is lost and no partial state remains.
- Invariant: skid_valid=1 implies main_valid=1.

Optional Feature:
- Macro ME_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - It saturates at all-ones and does not wrap.
  - It clears on reset only; flush does not clear it.
- Undefined: the stall_cnt port and counter logic are absent, with no other behavioural change.

Decomposition:
- Shared package (pipe_pkg):
  - default width constants DBITS, REG_INDEX_BIT_WIDTH, OPBITS.
  - packed payload struct me_payload_t {op, func, result, rd, wrReg}.
  - state encoding localparams ST_EMPTY, ST_ONE, ST_TWO for bench reference.
- Sub-module skid_buf_ctrl: handles the valid bits, in_ready, and load/move select. It is payload-agnostic so other stage registers can reuse it.
- The top level instantiates the controller plus two payload registers.

Test Plan:
- Reset: assert reset mid-cycle -> out_valid=0, ME_wrReg=0, ME_result=0, in_ready=1 without waiting for a clock edge.
- Streaming: out_ready=1, in_valid=1, 8 entries with result=0x1..0x8, rd=1..8 -> out_valid rises 1 cycle after the first accept, in_ready stays 1, outputs appear in order 0x1..0x8 on consecutive cycles.
- Stall/skid: deliver A=0xAAAA then B=0xBBBB with out_ready=0 -> in_ready=0 after B, ME_result holds 0xAAAA. Raise out_ready -> outputs A then B, and in_ready returns to 1.
- Flush in TWO with in_valid=1, C=0xCCCC -> next cycle out_valid=0, ME_wrReg=0, C never appears, in_ready=1.
- wrReg qualification: accept wrReg=1 rd=5, consume it, then idle -> ME_wrReg=1 for exactly one cycle, then 0 while ME_rd still reads 5.
- ME_STALL_CNT_EN with CNTBITS=4: hold one entry stalled 20 cycles -> stall_cnt reaches 15 and stays. Flush leaves it at 15; reset clears it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, payload layout and state encoding for the pipeline stage registers.
package pipe_pkg;

   localparam int unsigned DBITS               = 32;
   localparam int unsigned REG_INDEX_BIT_WIDTH = 4;
   localparam int unsigned OPBITS              = 4;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Default-width view of a MEM->WB entry.
   typedef struct packed {
      logic [OPBITS-1:0]              op;
      logic [OPBITS-1:0]              func;
      logic [DBITS-1:0]               result;
      logic [REG_INDEX_BIT_WIDTH-1:0] rd;
      logic                           wrReg;
   } me_payload_t;

endpackage

// File: rtl/skid_buf_ctrl.sv
// Payload-agnostic control for a main register plus one-entry skid buffer:
// valid bits, in_ready and the load/move selects for the payload registers.
module skid_buf_ctrl
   import pipe_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic load_main,
   output logic load_skid,
   output logic main_from_skid
);

   typedef enum logic [1:0] {
      StEmpty = ST_EMPTY,
      StOne   = ST_ONE,
      StTwo   = ST_TWO
   } state_e;

   state_e state_q, state_d;
   logic   accept, consume;

   // Handshake outputs decode registered state only; no path from out_ready.
   assign out_valid = (state_q != StEmpty);
   assign in_ready  = (state_q != StTwo);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d   = StOne;
                  load_main = 1'b1;
               end
            end
            StOne: begin
               if (accept && consume) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_d   = StTwo;
                  load_skid = 1'b1;
               end else if (consume) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (consume) begin
                  state_d        = StOne;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

endmodule

// File: rtl/me_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, skid buffer and flush.
// Optional stall counter enabled by defining ME_STALL_CNT_EN.
module me_wb_pipe_reg #(
   parameter int unsigned DBITS               = pipe_pkg::DBITS,
   parameter int unsigned REG_INDEX_BIT_WIDTH = pipe_pkg::REG_INDEX_BIT_WIDTH,
   parameter int unsigned OPBITS              = pipe_pkg::OPBITS,
   parameter int unsigned CNTBITS             = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [OPBITS-1:0]              op,
   input  logic [OPBITS-1:0]              func,
   input  logic [DBITS-1:0]               result,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
   input  logic                           wrReg,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OPBITS-1:0]              ME_op,
   output logic [OPBITS-1:0]              ME_func,
   output logic [DBITS-1:0]               ME_result,
   output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
   output logic                           ME_wrReg
`ifdef ME_STALL_CNT_EN
   ,
   output logic [CNTBITS-1:0]             stall_cnt
`endif
);

   // Same layout as pipe_pkg::me_payload_t, sized by this instance's parameters.
   typedef struct packed {
      logic [OPBITS-1:0]              op;
      logic [OPBITS-1:0]              func;
      logic [DBITS-1:0]               result;
      logic [REG_INDEX_BIT_WIDTH-1:0] rd;
      logic                           wrReg;
   } payload_t;

   payload_t in_pl, main_d, main_q, skid_q;
   logic     load_main, load_skid, main_from_skid;

   skid_buf_ctrl u_ctrl (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .out_ready      (out_ready),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .load_main      (load_main),
      .load_skid      (load_skid),
      .main_from_skid (main_from_skid)
   );

   assign in_pl = {op, func, result, rd, wrReg};

   always_comb begin
      main_d = main_from_skid ? skid_q : in_pl;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) main_q <= main_d;
         if (load_skid) skid_q <= in_pl;
      end
   end

   assign ME_op     = main_q.op;
   assign ME_func   = main_q.func;
   assign ME_result = main_q.result;
   assign ME_rd     = main_q.rd;
   // Payload goes stale when emptied; only the write strobe must be qualified.
   assign ME_wrReg  = main_q.wrReg & out_valid;

`ifdef ME_STALL_CNT_EN
   logic [CNTBITS-1:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (out_valid && !out_ready && (stall_cnt_q != {CNTBITS{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNTBITS'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_me_wb_pipe_reg.sv
// Self-checking bench for me_wb_pipe_reg: FIFO-level reference model feeding a
// scoreboard queue, directed scenarios plus randomized traffic.
module tb_me_wb_pipe_reg;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [3:0]  func;
   logic [31:0] result;
   logic [3:0]  rd;
   logic        wrReg;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ME_op;
   logic [3:0]  ME_func;
   logic [31:0] ME_result;
   logic [3:0]  ME_rd;
   logic        ME_wrReg;
`ifdef ME_STALL_CNT_EN
   logic [3:0]  stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   me_payload_t drv_pl;
   me_payload_t exp_q[$];

   always #5 clk = ~clk;

`ifdef ME_STALL_CNT_EN
   me_wb_pipe_reg #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .OPBITS(4), .CNTBITS(4)) dut (
`else
   me_wb_pipe_reg #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .OPBITS(4)) dut (
`endif
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .func      (func),
      .result    (result),
      .rd        (rd),
      .wrReg     (wrReg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ME_op     (ME_op),
      .ME_func   (ME_func),
      .ME_result (ME_result),
      .ME_rd     (ME_rd),
      .ME_wrReg  (ME_wrReg)
`ifdef ME_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic me_payload_t mk(input logic [3:0] o, input logic [3:0] f,
                                      input logic [31:0] r, input logic [3:0] d,
                                      input logic w);
      me_payload_t p;
      p.op = o; p.func = f; p.result = r; p.rd = d; p.wrReg = w;
      return p;
   endfunction

   task automatic set_in(input logic v, input me_payload_t p, input logic ordy, input logic fl);
      in_valid  = v;
      drv_pl    = p;
      op        = p.op;
      func      = p.func;
      result    = p.result;
      rd        = p.rd;
      wrReg     = p.wrReg;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic next_neg;
      @(negedge clk);
   endtask

   // Reference model: the stage behaves as an ordered queue holding at most two
   // entries; flush empties it, input is taken whenever fewer than two are held.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
      end else if (flush) begin
         exp_q.delete();
      end else if (in_valid && exp_q.size() < 2) begin
         if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         exp_q.push_back(drv_pl);
      end else if (out_ready && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end
   end

   // Monitor: outputs are stable between edges; compare against the queue head.
   always @(negedge clk) begin
      if (!reset) begin
         chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         if (exp_q.size() > 0) begin
            chk("mon_payload", 64'({ME_op, ME_func, ME_result, ME_rd, ME_wrReg}), 64'(exp_q[0]));
         end else begin
            chk("mon_wrreg_idle", 64'(ME_wrReg), 64'd0);
         end
      end
   end

   initial begin
      reset = 1'b1;
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b0);
      repeat (2) next_neg;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_result", 64'(ME_result), 64'd0);
      chk("reset_wrreg", 64'(ME_wrReg), 64'd0);
      #1 reset = 1'b0;

      // Streaming at full rate.
      next_neg;
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b1, mk(4'(i), 4'(i + 1), 32'(i), 4'(i), 1'b1), 1'b1, 1'b0);
         next_neg;
         chk("stream_out_valid", 64'(out_valid), 64'd1);
         chk("stream_result", 64'(ME_result), 64'(i));
         chk("stream_in_ready", 64'(in_ready), 64'd1);
      end
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b1, 1'b0);
      next_neg;
      chk("stream_drained", 64'(out_valid), 64'd0);

      // Stall into the skid buffer, then release.
      set_in(1'b1, mk(4'h1, 4'h2, 32'hAAAA, 4'h3, 1'b1), 1'b0, 1'b0);
      next_neg;
      set_in(1'b1, mk(4'h4, 4'h5, 32'hBBBB, 4'h6, 1'b0), 1'b0, 1'b0);
      next_neg;
      chk("skid_in_ready", 64'(in_ready), 64'd0);
      chk("skid_hold_a", 64'(ME_result), 64'hAAAA);
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b1, 1'b0);
      next_neg;
      chk("skid_then_b", 64'(ME_result), 64'hBBBB);
      chk("skid_ready_back", 64'(in_ready), 64'd1);
      next_neg;
      chk("skid_drained", 64'(out_valid), 64'd0);

      // Flush while full, with a new entry offered in the same cycle.
      set_in(1'b1, mk(4'h1, 4'h1, 32'h1111, 4'h1, 1'b1), 1'b0, 1'b0);
      next_neg;
      set_in(1'b1, mk(4'h2, 4'h2, 32'h2222, 4'h2, 1'b1), 1'b0, 1'b0);
      next_neg;
      set_in(1'b1, mk(4'h3, 4'h3, 32'hCCCC, 4'h3, 1'b1), 1'b0, 1'b1);
      next_neg;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_wrreg", 64'(ME_wrReg), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b1, 1'b0);
      repeat (3) begin
         next_neg;
         chk("flush_c_dropped", 64'(out_valid), 64'd0);
      end

      // Write strobe is qualified by valid; payload stays stale afterwards.
      set_in(1'b1, mk(4'h7, 4'h8, 32'h5555, 4'h5, 1'b1), 1'b1, 1'b0);
      next_neg;
      chk("wr_strobe_on", 64'(ME_wrReg), 64'd1);
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b1, 1'b0);
      next_neg;
      chk("wr_strobe_off", 64'(ME_wrReg), 64'd0);
      chk("wr_stale_rd", 64'(ME_rd), 64'd5);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 7,
                mk(4'($urandom), 4'($urandom), $urandom, 4'($urandom), 1'($urandom)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         next_neg;
      end

      // Asynchronous reset in the middle of a cycle with an entry held.
      set_in(1'b1, mk(4'h9, 4'h9, 32'h1234, 4'h9, 1'b1), 1'b0, 1'b0);
      next_neg;
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("async_out_valid", 64'(out_valid), 64'd0);
      chk("async_wrreg", 64'(ME_wrReg), 64'd0);
      chk("async_result", 64'(ME_result), 64'd0);
      chk("async_in_ready", 64'(in_ready), 64'd1);
      next_neg;
      #1 reset = 1'b0;

`ifdef ME_STALL_CNT_EN
      next_neg;
      chk("stall_cnt_reset", 64'(stall_cnt), 64'd0);
      set_in(1'b1, mk(4'h1, 4'h1, 32'hABCD, 4'h1, 1'b1), 1'b0, 1'b0);
      next_neg;
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b0);
      next_neg;
      chk("stall_cnt_one", 64'(stall_cnt), 64'd1);
      repeat (20) next_neg;
      chk("stall_cnt_sat", 64'(stall_cnt), 64'd15);
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b1);
      next_neg;
      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b0);
      chk("stall_cnt_flush", 64'(stall_cnt), 64'd15);
      #2 reset = 1'b1;
      #1;
      chk("stall_cnt_clear", 64'(stall_cnt), 64'd0);
      next_neg;
      #1 reset = 1'b0;
`endif

      set_in(1'b0, mk(4'h0, 4'h0, 32'h0, 4'h0, 1'b0), 1'b0, 1'b0);
      next_neg;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
